fast_line_port: RTL and testbench

Host-side access port for one 4-word (116-bit) fast memory line. It turns parallel read/write requests from the FPGA host side into bit-serial traffic on the drum-line interface. The line itself only understands a serial write bus, a write gate and a recirculating output, so this block drives the write bus and gate and receives the recirculating output. It keeps a free-running bit/word position locked to a line-origin marker, waits for the addressed word to come round, then shifts the 29-bit word out of or into the line, LSB first.

---
 rtl/fast_line_port.sv | 168 ++++++++++++++++
 tb/tb_fast_line_port.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fast_line_port.sv
// Host access port for one fast memory line: parallel word requests
// become LSB-first serial traffic locked to the line-origin marker.
module fast_line_port #(
    parameter int WORD_BITS = 29,
    parameter int WORDS     = 4
) (
    input  logic                 CLOCK,
    input  logic                 RST_N,
    input  logic                 SYNC,
    input  logic                 LINE_OUT,
    output logic                 LB,
    output logic                 WR_GATE,
    input  logic                 REQ,
    input  logic                 WE,
    input  logic [1:0]           ADDR,
    input  logic [WORD_BITS-1:0] WDATA,
    output logic                 ACK,
    output logic [WORD_BITS-1:0] RDATA,
    output logic                 BUSY,
    output logic                 LOCKED,
    output logic                 SYNC_ERR
);

    localparam int LINE_LEN = WORD_BITS * WORDS;
    localparam int PW       = $clog2(LINE_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_XFER,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [PW-1:0]        r_pos;
    logic [PW-1:0]        w_pos;
    logic [PW-1:0]        w_pos_nxt;
    logic [PW-1:0]        w_base;
    logic                 r_locked;
    logic                 r_sync_err;
    logic                 r_we;
    logic [1:0]           r_addr;
    logic [WORD_BITS-1:0] r_wdata;
    logic [WORD_BITS-2:0] r_rsh;
    logic [WORD_BITS-1:0] r_wsh;
    logic [WORD_BITS-1:0] r_rdata;
    logic                 r_lb;
    logic                 r_wr_gate;
    logic                 w_realign;
    logic                 w_accept;
    logic                 w_we;
    logic [WORD_BITS-1:0] w_wdata;
    logic                 w_start;
    logic                 w_last;
    logic                 w_enter;
    logic                 w_ack;
    logic                 w_busy;

    assign w_pos     = SYNC ? '0 : r_pos;
    assign w_pos_nxt = (w_pos == PW'(LINE_LEN - 1)) ? '0 : w_pos + PW'(1);
    assign w_realign = SYNC & r_locked & (r_pos != '0);
    assign w_accept  = (r_state == S_IDLE) & REQ & r_locked;
    assign w_we      = w_accept ? WE : r_we;
    assign w_wdata   = w_accept ? WDATA : r_wdata;
    assign w_base    = PW'(WORD_BITS * int'(w_accept ? ADDR : r_addr));
    assign w_start   = (w_pos_nxt == w_base);
    assign w_last    = (w_pos == w_base + PW'(WORD_BITS - 1));

    // Serial outputs are decoded a cycle early; a bad SYNC kills them at once.
    assign w_enter  = (w_state_nxt == S_XFER) & ((r_state != S_XFER) | w_realign);
    assign LB       = r_lb & ~w_realign;
    assign WR_GATE  = r_wr_gate & ~w_realign;
    assign ACK      = w_ack;
    assign BUSY     = w_busy;
    assign RDATA    = r_rdata;
    assign LOCKED   = r_locked;
    assign SYNC_ERR = r_sync_err;

    always_ff @(posedge CLOCK or negedge RST_N) begin
        if (!RST_N) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = w_start ? S_XFER : S_WAIT;
            S_WAIT: if (w_start) w_state_nxt = S_XFER;
            S_XFER: begin
                if (w_realign)   w_state_nxt = w_start ? S_XFER : S_WAIT;
                else if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_ack  = 1'b0;
        w_busy = 1'b0;
        unique case (r_state)
            S_IDLE: w_busy = 1'b0;
            S_WAIT: w_busy = 1'b1;
            S_XFER: w_busy = 1'b1;
            S_DONE: begin
                w_ack  = 1'b1;
                w_busy = 1'b1;
            end
            default: w_busy = 1'b0;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RST_N) begin
        if (!RST_N) begin
            r_pos      <= '0;
            r_locked   <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            r_pos <= w_pos_nxt;
            if (SYNC)      r_locked   <= 1'b1;
            if (w_realign) r_sync_err <= 1'b1;
        end
    end

    always_ff @(posedge CLOCK or negedge RST_N) begin
        if (!RST_N) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_we    <= WE;
            r_addr  <= ADDR;
            r_wdata <= WDATA;
        end
    end

    always_ff @(posedge CLOCK or negedge RST_N) begin
        if (!RST_N) begin
            r_rsh   <= '0;
            r_rdata <= '0;
        end else if (r_state == S_XFER) begin
            r_rsh <= {LINE_OUT, r_rsh[WORD_BITS-2:1]};
            if (w_state_nxt == S_DONE)
                r_rdata <= r_we ? r_wdata : {LINE_OUT, r_rsh};
        end
    end

    always_ff @(posedge CLOCK or negedge RST_N) begin
        if (!RST_N) begin
            r_wsh     <= '0;
            r_lb      <= 1'b0;
            r_wr_gate <= 1'b0;
        end else if (w_enter) begin
            r_wsh     <= w_wdata >> 1;
            r_lb      <= w_we & w_wdata[0];
            r_wr_gate <= w_we;
        end else if (w_state_nxt == S_XFER) begin
            r_wsh     <= r_wsh >> 1;
            r_lb      <= r_we & r_wsh[0];
            r_wr_gate <= r_we;
        end else begin
            r_lb      <= 1'b0;
            r_wr_gate <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fast_line_port.sv
// Bench for fast_line_port: 116-bit recirculating line model plus
// directed request vectors and realign/reset sequences.
module tb_fast_line_port;

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [28:0] wdata;
        int          acc;
        logic [28:0] exp_rd;
        int          exp_lat;
        int          exp_ackpos;
    } vec_t;

    logic        CLOCK = 1'b0;
    logic        RST_N = 1'b1;
    logic        REQ = 1'b0;
    logic        WE = 1'b0;
    logic [1:0]  ADDR = 2'd0;
    logic [28:0] WDATA = '0;
    logic        SYNC;
    logic        LINE_OUT;
    logic        LB;
    logic        WR_GATE;
    logic        ACK;
    logic [28:0] RDATA;
    logic        BUSY;
    logic        LOCKED;
    logic        SYNC_ERR;

    logic [115:0] mem = {29'h0000003, 29'h10000001, 29'h01234567, 29'h0C3A5F96};
    logic [6:0]   tb_pos = 7'd0;
    logic         sync_force = 1'b0;
    int           n_cmp = 0;
    int           n_err = 0;
    vec_t         v[8];

    fast_line_port dut (
        .CLOCK    (CLOCK),
        .RST_N    (RST_N),
        .SYNC     (SYNC),
        .LINE_OUT (LINE_OUT),
        .LB       (LB),
        .WR_GATE  (WR_GATE),
        .REQ      (REQ),
        .WE       (WE),
        .ADDR     (ADDR),
        .WDATA    (WDATA),
        .ACK      (ACK),
        .RDATA    (RDATA),
        .BUSY     (BUSY),
        .LOCKED   (LOCKED),
        .SYNC_ERR (SYNC_ERR)
    );

    always #5 CLOCK = ~CLOCK;

    assign SYNC     = (tb_pos == 7'd0) | sync_force;
    assign LINE_OUT = mem[tb_pos];

    // The line rotates regardless of the port; the gate overwrites the current bit.
    always @(posedge CLOCK) begin
        if (WR_GATE) mem[tb_pos] <= LB;
        tb_pos <= (tb_pos == 7'd115) ? 7'd0 : tb_pos + 7'd1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_pos(input int p);
        int n;
        n = 0;
        while (int'(tb_pos) != p && n < 300) begin
            @(negedge CLOCK);
            n++;
        end
        chk($sformatf("wait_pos_%0d", p), int'(tb_pos), p);
    endtask

    function automatic logic [28:0] word_of(input int a);
        return mem[29*a +: 29];
    endfunction

    initial begin
        int bad;
        int base;
        int lat;
        int gcnt;
        int gbad;
        int p;
        bit got;

        v[0] = '{1'b1, 2'd2, 29'h1ABCDEF1, 5,  29'h1ABCDEF1, 82,  87};
        v[1] = '{1'b0, 2'd2, 29'h0,        10, 29'h1ABCDEF1, 77,  87};
        v[2] = '{1'b0, 2'd0, 29'h0,        0,  29'h0C3A5F96, 145, 29};
        v[3] = '{1'b1, 2'd3, 29'h15555AAA, 40, 29'h15555AAA, 76,  0};
        v[4] = '{1'b0, 2'd3, 29'h0,        1,  29'h15555AAA, 115, 0};
        v[5] = '{1'b1, 2'd1, 29'h1FFFFFFF, 28, 29'h1FFFFFFF, 30,  58};
        v[6] = '{1'b0, 2'd1, 29'h0,        58, 29'h1FFFFFFF, 116, 58};
        v[7] = '{1'b0, 2'd1, 29'h0,        29, 29'h1FFFFFFF, 145, 58};

        #2 RST_N = 1'b0;
        #1;
        chk("reset_ctl", {26'd0, LB, WR_GATE, ACK, BUSY, LOCKED, SYNC_ERR}, 32'd0);
        chk("reset_rdata", {3'd0, RDATA}, 32'd0);
        wait_pos(10);
        RST_N = 1'b1;

        bad = 0;
        while (tb_pos != 7'd115) begin
            @(negedge CLOCK);
            if (WR_GATE || ACK || BUSY || LB) bad++;
        end
        chk("unlocked_before_sync", {31'd0, LOCKED}, 32'd0);
        @(negedge CLOCK);
        @(negedge CLOCK);
        chk("locked_after_sync", {31'd0, LOCKED}, 32'd1);
        wait_pos(0);
        @(negedge CLOCK);
        chk("idle_outputs_quiet", bad, 0);
        chk("no_sync_err_aligned", {31'd0, SYNC_ERR}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            base = 29 * int'(v[i].addr);
            wait_pos(v[i].acc);
            REQ   = 1'b1;
            WE    = v[i].we;
            ADDR  = v[i].addr;
            WDATA = v[i].wdata;
            @(negedge CLOCK);
            REQ = 1'b0;
            lat = 1;
            chk($sformatf("v%0d_busy_start", i), {31'd0, BUSY}, 32'd1);
            gcnt = 0;
            gbad = 0;
            got  = 1'b0;
            while (!got && lat <= 200) begin
                if (WR_GATE) begin
                    gcnt++;
                    p = int'(tb_pos);
                    if (p < base || p > base + 28) gbad++;
                    else if (LB !== v[i].wdata[p-base]) gbad++;
                end
                if (ACK) got = 1'b1;
                else begin
                    @(negedge CLOCK);
                    lat++;
                end
            end
            chk($sformatf("v%0d_ack_seen", i), {31'd0, got}, 32'd1);
            chk($sformatf("v%0d_latency", i), lat, v[i].exp_lat);
            chk($sformatf("v%0d_ack_pos", i), int'(tb_pos), v[i].exp_ackpos);
            chk($sformatf("v%0d_rdata", i), {3'd0, RDATA}, {3'd0, v[i].exp_rd});
            chk($sformatf("v%0d_busy_ack", i), {31'd0, BUSY}, 32'd1);
            chk($sformatf("v%0d_gate_cycles", i), gcnt, v[i].we ? 29 : 0);
            chk($sformatf("v%0d_gate_data", i), gbad, 0);
            if (v[i].we)
                chk($sformatf("v%0d_line_word", i), {3'd0, word_of(int'(v[i].addr))},
                    {3'd0, v[i].wdata});
            @(negedge CLOCK);
            chk($sformatf("v%0d_idle_after", i), {30'd0, BUSY, ACK}, 32'd0);
        end
        chk("no_sync_err_table", {31'd0, SYNC_ERR}, 32'd0);

        wait_pos(30);
        REQ   = 1'b1;
        WE    = 1'b1;
        ADDR  = 2'd2;
        WDATA = 29'h0F0F1234;
        @(negedge CLOCK);
        REQ = 1'b0;
        wait_pos(69);
        chk("rl_gate_before", {30'd0, WR_GATE, LB}, {30'd0, 1'b1, WDATA[11]});
        @(negedge CLOCK);
        sync_force = 1'b1;
        #1;
        chk("rl_gate_drop", {30'd0, WR_GATE, ACK}, 32'd0);
        @(negedge CLOCK);
        sync_force = 1'b0;
        chk("rl_sync_err", {31'd0, SYNC_ERR}, 32'd1);
        lat  = 1;
        gcnt = 0;
        gbad = 0;
        got  = 1'b0;
        while (!got && lat <= 300) begin
            if (WR_GATE) begin
                gcnt++;
                p = int'(tb_pos);
                if (p < 58 || p > 86) gbad++;
                else if (LB !== WDATA[p-58]) gbad++;
            end
            if (ACK) got = 1'b1;
            else begin
                @(negedge CLOCK);
                lat++;
            end
        end
        chk("rl_ack_seen", {31'd0, got}, 32'd1);
        chk("rl_ack_delay", lat, 133);
        chk("rl_ack_pos", int'(tb_pos), 87);
        chk("rl_gate_cycles", gcnt, 29);
        chk("rl_gate_data", gbad, 0);
        chk("rl_line_word", {3'd0, word_of(2)}, 32'h0F0F1234);
        chk("rl_rdata", {3'd0, RDATA}, 32'h0F0F1234);
        chk("rl_locked", {30'd0, LOCKED, SYNC_ERR}, 32'd3);
        @(negedge CLOCK);

        wait_pos(30);
        REQ   = 1'b1;
        WE    = 1'b1;
        ADDR  = 2'd2;
        WDATA = 29'h1FFFFFFF;
        @(negedge CLOCK);
        REQ = 1'b0;
        wait_pos(65);
        chk("rst_gate_before", {31'd0, WR_GATE}, 32'd1);
        RST_N = 1'b0;
        #1;
        chk("rst_mid_ctl", {26'd0, LB, WR_GATE, ACK, BUSY, LOCKED, SYNC_ERR}, 32'd0);
        chk("rst_mid_rdata", {3'd0, RDATA}, 32'd0);
        repeat (3) @(negedge CLOCK);
        chk("rst_partial_kept", {25'd0, mem[64:58]}, 32'h7F);
        chk("rst_rest_untouched", {25'd0, mem[71:65]}, 32'h24);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
